// File: rtl/beatmap_pkg.sv
// Shared beat-map record layout, slot types and the depth-saturation helper
// used by block_window and block_selector.
package beatmap_pkg;

    localparam int NUM_SLOTS = 12;
    localparam logic [17:0] END_TIME = 18'h3FFFF;

    typedef logic [11:0]        coord_t;
    typedef logic signed [13:0] slot_z_t;
    typedef logic [7:0]         slot_id_t;
    typedef logic [2:0]         dir_t;

    typedef struct packed {
        logic [17:0] tick;
        coord_t      x;
        coord_t      y;
        logic        color;
        dir_t        dir;
    } beat_rec_t;

    typedef struct packed {
        logic        valid;
        logic [17:0] tick;
        coord_t      x;
        coord_t      y;
        logic        color;
        dir_t        dir;
        slot_id_t    id;
    } slot_t;

    function automatic slot_z_t sat_z(input logic signed [18:0] d);
        if (d > 19'sd8191) begin
            return 14'sd8191;
        end else if (d < -19'sd8192) begin
            return -14'sd8192;
        end else begin
            return d[13:0];
        end
    endfunction

endpackage

// File: rtl/beatmap_fetcher.sv
// Beat-map ROM reader: owns the read pointer, the ROM latency counter, the
// one-record pending buffer and the end-of-map flag.
module beatmap_fetcher #(
    parameter int ROM_AW      = 8,
    parameter int ROM_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clear_in,
    input  logic              req_in,
    input  logic              take_in,
    input  logic [45:0]       rom_data_in,
    output logic [ROM_AW-1:0] rom_addr_out,
    output logic              pend_valid_out,
    output logic [45:0]       pend_rec_out,
    output logic [ROM_AW-1:0] pend_id_out,
    output logic              ended_out
);
    import beatmap_pkg::*;

    localparam int LW = $clog2(ROM_LATENCY + 1);
    localparam logic [ROM_AW-1:0] PTR_MAX = '1;

    logic [ROM_AW-1:0] ptr_reg;
    logic              pend_valid_reg;
    logic              ended_reg;
    logic              in_flight_reg;
    logic [LW-1:0]     lat_cnt_reg;
    beat_rec_t         pend_reg;
    beat_rec_t         rom_rec;

    assign rom_rec = beat_rec_t'(rom_data_in);

    // The address is held at ptr continuously, so the ROM pipeline is already
    // primed by the time the counter expires.
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            ptr_reg        <= '0;
            pend_valid_reg <= 1'b0;
            ended_reg      <= 1'b0;
            in_flight_reg  <= 1'b0;
            lat_cnt_reg    <= '0;
            pend_reg       <= '0;
        end else begin
            if (take_in && pend_valid_reg) begin
                pend_valid_reg <= 1'b0;
                if (ptr_reg == PTR_MAX) begin
                    ended_reg <= 1'b1;
                end else begin
                    ptr_reg <= ptr_reg + ROM_AW'(1);
                end
            end
            if (in_flight_reg) begin
                if (lat_cnt_reg == LW'(1)) begin
                    in_flight_reg <= 1'b0;
                    if (rom_rec.tick == END_TIME) begin
                        ended_reg <= 1'b1;
                    end else begin
                        pend_reg       <= rom_rec;
                        pend_valid_reg <= 1'b1;
                    end
                end else begin
                    lat_cnt_reg <= lat_cnt_reg - LW'(1);
                end
            end else if (req_in && !pend_valid_reg && !ended_reg) begin
                in_flight_reg <= 1'b1;
                lat_cnt_reg   <= LW'(ROM_LATENCY);
            end
        end
    end

    assign rom_addr_out   = ptr_reg;
    assign pend_valid_out = pend_valid_reg;
    assign pend_rec_out   = pend_reg;
    assign pend_id_out    = ptr_reg;
    assign ended_out      = ended_reg;

endmodule

// File: rtl/block_window.sv
// Sliding window of upcoming beat-map blocks: retire, fetch, recompute depth,
// then commit the whole window to the outputs in a single cycle.
module block_window #(
    parameter int NUM_SLOTS    = 12,
    parameter int ROM_AW       = 8,
    parameter int ROM_LATENCY  = 2,
    parameter int LOOKAHEAD    = 4096,
    parameter int RETIRE_TICKS = 512
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 frame_in,
    input  logic [17:0]          curr_time_in,
    output logic [ROM_AW-1:0]    rom_addr_out,
    input  logic [45:0]          rom_data_in,
    output logic [11:0]          block_x_out [NUM_SLOTS],
    output logic [11:0]          block_y_out [NUM_SLOTS],
    output logic signed [13:0]   block_z_out [NUM_SLOTS],
    output logic [NUM_SLOTS-1:0] block_color_out,
    output logic [2:0]           block_direction_out [NUM_SLOTS],
    output logic [ROM_AW-1:0]    block_ID_out [NUM_SLOTS],
    output logic [NUM_SLOTS-1:0] block_visible_out,
    output logic                 busy_out,
    output logic                 commit_out,
    output logic                 frame_missed_out
);
    import beatmap_pkg::*;

    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam int ZW = $clog2(NUM_SLOTS);
    localparam logic signed [18:0] LOOK     = 19'(LOOKAHEAD);
    localparam logic [18:0]        RETIRE_W = 19'(RETIRE_TICKS);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RETIRE = 3'd1;
    localparam logic [2:0] FETCH  = 3'd2;
    localparam logic [2:0] ZCALC  = 3'd3;
    localparam logic [2:0] COMMIT = 3'd4;

    logic [2:0]        state_reg;
    logic [17:0]       t_snap_reg;
    logic [CW-1:0]     count_reg;
    logic [ZW-1:0]     zidx_reg;
    slot_t             sh_slot [NUM_SLOTS];
    slot_z_t           sh_z    [NUM_SLOTS];

    logic              pend_valid;
    logic              ended;
    logic [45:0]       pend_bits;
    logic [ROM_AW-1:0] pend_id;
    beat_rec_t         pend_rec;
    logic signed [18:0] pend_diff;
    logic              retire_shift;
    logic              append;
    logic              fetch_req;

    assign pend_rec  = beat_rec_t'(pend_bits);
    assign pend_diff = $signed({1'b0, pend_rec.tick}) - $signed({1'b0, t_snap_reg});
    assign retire_shift = (state_reg == RETIRE) && sh_slot[0].valid &&
                          ({1'b0, t_snap_reg} > ({1'b0, sh_slot[0].tick} + RETIRE_W));
    // Past-due pending blocks (negative diff) are appended and retire later.
    assign append    = (state_reg == FETCH) && pend_valid &&
                       (count_reg < CW'(NUM_SLOTS)) && (pend_diff <= LOOK);
    assign fetch_req = (state_reg == FETCH);
    assign busy_out  = (state_reg != IDLE);

    beatmap_fetcher #(
        .ROM_AW      (ROM_AW),
        .ROM_LATENCY (ROM_LATENCY)
    ) u_fetcher (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .clear_in       (start_in),
        .req_in         (fetch_req),
        .take_in        (append),
        .rom_data_in    (rom_data_in),
        .rom_addr_out   (rom_addr_out),
        .pend_valid_out (pend_valid),
        .pend_rec_out   (pend_bits),
        .pend_id_out    (pend_id),
        .ended_out      (ended)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in || start_in) begin
            state_reg <= IDLE;
            count_reg <= '0;
            zidx_reg  <= '0;
            if (rst_in) begin
                t_snap_reg <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (frame_in) begin
                        t_snap_reg <= curr_time_in;
                        state_reg  <= RETIRE;
                    end
                end
                RETIRE: begin
                    if (retire_shift) begin
                        count_reg <= count_reg - CW'(1);
                    end else begin
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (append) begin
                        count_reg <= count_reg + CW'(1);
                    end else if (pend_valid || ended) begin
                        state_reg <= ZCALC;
                        zidx_reg  <= '0;
                    end
                end
                ZCALC: begin
                    if (zidx_reg == ZW'(NUM_SLOTS - 1)) begin
                        state_reg <= COMMIT;
                    end else begin
                        zidx_reg <= zidx_reg + ZW'(1);
                    end
                end
                COMMIT:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            commit_out       <= 1'b0;
            frame_missed_out <= 1'b0;
        end else begin
            commit_out       <= !start_in && (state_reg == COMMIT);
            frame_missed_out <= frame_in && !start_in && (state_reg != IDLE);
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        slot_t              shift_src;
        slot_t              new_slot;
        logic signed [18:0] z_diff;

        if (gi < NUM_SLOTS - 1) begin : g_mid
            assign shift_src = sh_slot[gi+1];
        end else begin : g_tail
            assign shift_src = '0;
        end

        assign new_slot = '{valid: 1'b1, tick: pend_rec.tick, x: pend_rec.x, y: pend_rec.y,
                            color: pend_rec.color, dir: pend_rec.dir, id: slot_id_t'(pend_id)};
        assign z_diff = $signed({1'b0, sh_slot[gi].tick}) - $signed({1'b0, t_snap_reg});

        always_ff @(posedge clk_in) begin
            if (rst_in || start_in) begin
                sh_slot[gi] <= '0;
                sh_z[gi]    <= '0;
            end else if (retire_shift) begin
                sh_slot[gi] <= shift_src;
            end else if (append && (count_reg == CW'(gi))) begin
                sh_slot[gi] <= new_slot;
            end else if ((state_reg == ZCALC) && (zidx_reg == ZW'(gi))) begin
                sh_z[gi] <= sh_slot[gi].valid ? sat_z(z_diff) : '0;
            end
        end

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                block_x_out[gi]         <= '0;
                block_y_out[gi]         <= '0;
                block_z_out[gi]         <= '0;
                block_color_out[gi]     <= 1'b0;
                block_direction_out[gi] <= '0;
                block_ID_out[gi]        <= '0;
                block_visible_out[gi]   <= 1'b0;
            end else if (start_in) begin
                block_visible_out[gi] <= 1'b0;
            end else if (state_reg == COMMIT) begin
                block_x_out[gi]         <= sh_slot[gi].x;
                block_y_out[gi]         <= sh_slot[gi].y;
                block_z_out[gi]         <= sh_z[gi];
                block_color_out[gi]     <= sh_slot[gi].color;
                block_direction_out[gi] <= sh_slot[gi].dir;
                block_ID_out[gi]        <= ROM_AW'(sh_slot[gi].id);
                block_visible_out[gi]   <= sh_slot[gi].valid;
            end
        end
    end

endmodule

// File: tb/tb_block_window.sv
// Scenario tasks plus a randomized map/frame sequence checked against a
// queue-based model of the window.
module tb_block_window;
    localparam int NS = 12;

    logic              clk_in = 1'b0;
    logic              rst_in, start_in, frame_in;
    logic [17:0]       curr_time_in;
    logic [7:0]        rom_addr_out;
    logic [45:0]       rom_data_in;
    logic [11:0]       block_x_out [NS];
    logic [11:0]       block_y_out [NS];
    logic signed [13:0] block_z_out [NS];
    logic [NS-1:0]     block_color_out;
    logic [2:0]        block_direction_out [NS];
    logic [7:0]        block_ID_out [NS];
    logic [NS-1:0]     block_visible_out;
    logic              busy_out, commit_out, frame_missed_out;

    logic              start_b, frame_b;
    logic [17:0]       time_b;
    logic [7:0]        rom_addr_b;
    logic [45:0]       rom_data_b;
    logic [11:0]       x_b [NS];
    logic [11:0]       y_b [NS];
    logic signed [13:0] z_b [NS];
    logic [NS-1:0]     color_b;
    logic [2:0]        dir_b [NS];
    logic [7:0]        id_b [NS];
    logic [NS-1:0]     vis_b;
    logic              busy_b, commit_b, missed_b;

    block_window dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .frame_in(frame_in),
        .curr_time_in(curr_time_in), .rom_addr_out(rom_addr_out), .rom_data_in(rom_data_in),
        .block_x_out(block_x_out), .block_y_out(block_y_out), .block_z_out(block_z_out),
        .block_color_out(block_color_out), .block_direction_out(block_direction_out),
        .block_ID_out(block_ID_out), .block_visible_out(block_visible_out),
        .busy_out(busy_out), .commit_out(commit_out), .frame_missed_out(frame_missed_out)
    );

    block_window #(.LOOKAHEAD(16000)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_b), .frame_in(frame_b),
        .curr_time_in(time_b), .rom_addr_out(rom_addr_b), .rom_data_in(rom_data_b),
        .block_x_out(x_b), .block_y_out(y_b), .block_z_out(z_b),
        .block_color_out(color_b), .block_direction_out(dir_b),
        .block_ID_out(id_b), .block_visible_out(vis_b),
        .busy_out(busy_b), .commit_out(commit_b), .frame_missed_out(missed_b)
    );

    always #5 clk_in = ~clk_in;

    // Two-cycle ROMs
    logic [45:0] rom_mem [256];
    logic [45:0] rom_b_mem [256];
    logic [45:0] d1, d2, db1, db2;
    always @(posedge clk_in) begin
        d1  <= rom_mem[rom_addr_out];
        d2  <= d1;
        db1 <= rom_b_mem[rom_addr_b];
        db2 <= db1;
    end
    assign rom_data_in = d2;
    assign rom_data_b  = db2;

    int errors = 0;
    int checks = 0;
    int max_addr = 0;

    // Model: window is a queue of block IDs; m_pend means rom_mem[m_ptr] is held.
    int m_ptr;
    bit m_ended, m_pend;
    int m_win[$];

    function automatic logic [45:0] mk_rec(int t, int x, int y, int c, int d);
        return {18'(t), 12'(x), 12'(y), 1'(c), 3'(d)};
    endfunction

    function automatic int rec_time(int id);
        logic [45:0] r;
        r = rom_mem[id];
        return int'(r[45:28]);
    endfunction

    task automatic model_start();
        m_ptr = 0; m_ended = 0; m_pend = 0;
        m_win.delete();
    endtask

    task automatic model_frame(input int t);
        while (m_win.size() > 0 && t > rec_time(m_win[0]) + 512) void'(m_win.pop_front());
        forever begin
            if (!m_pend && !m_ended) begin
                if (rec_time(m_ptr) == 'h3FFFF) m_ended = 1;
                else m_pend = 1;
            end
            if (!m_pend) break;
            if (m_win.size() < NS && rec_time(m_ptr) - t <= 4096) begin
                m_win.push_back(m_ptr);
                m_pend = 0;
                if (m_ptr == 255) m_ended = 1;
                else m_ptr++;
            end else begin
                break;
            end
        end
    endtask

    task automatic fill_sentinel();
        for (int i = 0; i < 256; i++) begin
            rom_mem[i]   = mk_rec('h3FFFF, 0, 0, 0, 0);
            rom_b_mem[i] = mk_rec('h3FFFF, 0, 0, 0, 0);
        end
    endtask

    task automatic load_ramp();
        fill_sentinel();
        for (int i = 0; i < 15; i++) rom_mem[i] = mk_rec(100 * (i + 1), i * 7, i * 3, i & 1, i % 8);
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    task automatic do_frame(input int t);
        int n;
        curr_time_in = 18'(t);
        frame_in = 1'b1;
        @(negedge clk_in);
        frame_in = 1'b0;
        n = 0;
        while (commit_out !== 1'b1 && n < 400) begin
            if (int'(rom_addr_out) > max_addr) max_addr = int'(rom_addr_out);
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (commit_out !== 1'b1) begin
            errors++;
            $display("FAIL commit_timeout t=%0d: commit_out=%b required 1 within 400 cycles", t, commit_out);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy_out, commit_out, frame_missed_out, busy_b} !== 4'b0 || rom_addr_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b commit=%b missed=%b addr=%0d required 0", busy_out, commit_out, frame_missed_out, rom_addr_out);
        end
        checks++;
        if (block_visible_out !== '0 || block_color_out !== '0) begin
            errors++;
            $display("FAIL reset_vis: visible=%h color=%h required 0", block_visible_out, block_color_out);
        end
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (block_x_out[i] !== 12'd0 || block_y_out[i] !== 12'd0 || block_z_out[i] !== 14'sd0 ||
                block_ID_out[i] !== 8'd0 || block_direction_out[i] !== 3'd0) begin
                errors++;
                $display("FAIL reset_slot%0d: x=%0d y=%0d z=%0d id=%0d dir=%0d required all 0", i,
                         block_x_out[i], block_y_out[i], block_z_out[i], block_ID_out[i], block_direction_out[i]);
            end
        end
    endtask

    task automatic test_fill_and_retire();
        logic signed [13:0] ez;
        load_ramp();
        pulse_start();
        do_frame(0);
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (block_visible_out[i] !== 1'b1 || block_ID_out[i] !== 8'(i) || block_x_out[i] !== 12'(i * 7)) begin
                errors++;
                $display("FAIL fill_slot%0d: vis=%b id=%0d x=%0d required vis=1 id=%0d x=%0d", i,
                         block_visible_out[i], block_ID_out[i], block_x_out[i], i, i * 7);
            end
        end
        ez = 14'sd100;
        checks++;
        if (block_z_out[0] !== ez) begin
            errors++;
            $display("FAIL fill_z0: z=%0d required %0d", block_z_out[0], ez);
        end
        do_frame(700);
        ez = 14'(-500);
        checks++;
        if (block_ID_out[0] !== 8'd1 || block_z_out[0] !== ez) begin
            errors++;
            $display("FAIL retire_slot0: id=%0d z=%0d required id=1 z=%0d", block_ID_out[0], block_z_out[0], ez);
        end
        checks++;
        if (block_ID_out[11] !== 8'd12 || block_visible_out[11] !== 1'b1) begin
            errors++;
            $display("FAIL retire_append: slot11 id=%0d vis=%b required id=12 vis=1", block_ID_out[11], block_visible_out[11]);
        end
    endtask

    task automatic test_end_of_map();
        fill_sentinel();
        for (int i = 0; i < 3; i++) rom_mem[i] = mk_rec(100 * (i + 1), 5, 5, 1, 2);
        pulse_start();
        max_addr = 0;
        do_frame(0);
        for (int i = 0; i < NS; i++) begin
            checks++;
            if (block_visible_out[i] !== (i < 3) || (i >= 3 && block_z_out[i] !== 14'sd0)) begin
                errors++;
                $display("FAIL eom_slot%0d: vis=%b z=%0d required vis=%0d z=%0s", i, block_visible_out[i],
                         block_z_out[i], (i < 3), (i < 3) ? "any" : "0");
            end
        end
        do_frame(50);
        do_frame(300);
        checks++;
        if (max_addr > 3) begin
            errors++;
            $display("FAIL eom_addr: max rom_addr=%0d required <= 3", max_addr);
        end
    endtask

    task automatic test_lookahead();
        int n;
        logic signed [13:0] ez;
        fill_sentinel();
        rom_mem[0]   = mk_rec(9000, 1, 2, 0, 3);
        rom_b_mem[0] = mk_rec(12000, 1, 2, 0, 3);
        pulse_start();
        do_frame(0);
        checks++;
        if (block_visible_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL lookahead_far: slot0 vis=%b required 0", block_visible_out[0]);
        end
        do_frame(5096);
        ez = 14'sd3904;
        checks++;
        if (block_visible_out[0] !== 1'b1 || block_z_out[0] !== ez || block_ID_out[0] !== 8'd0) begin
            errors++;
            $display("FAIL lookahead_in: vis=%b z=%0d id=%0d required vis=1 z=%0d id=0",
                     block_visible_out[0], block_z_out[0], block_ID_out[0], ez);
        end
        start_b = 1'b1;
        @(negedge clk_in);
        start_b = 1'b0;
        time_b = 18'd0;
        frame_b = 1'b1;
        @(negedge clk_in);
        frame_b = 1'b0;
        n = 0;
        while (commit_b !== 1'b1 && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        ez = 14'sd8191;
        checks++;
        if (commit_b !== 1'b1 || vis_b[0] !== 1'b1 || z_b[0] !== ez) begin
            errors++;
            $display("FAIL z_saturate: commit=%b vis=%b z=%0d required commit=1 vis=1 z=%0d", commit_b, vis_b[0], z_b[0], ez);
        end
    endtask

    task automatic test_back_to_back();
        int commits;
        load_ramp();
        pulse_start();
        curr_time_in = 18'd0;
        frame_in = 1'b1;
        @(negedge clk_in);
        frame_in = 1'b0;
        checks++;
        if (frame_missed_out !== 1'b0 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL first_frame: missed=%b busy=%b required missed=0 busy=1", frame_missed_out, busy_out);
        end
        repeat (2) @(negedge clk_in);
        frame_in = 1'b1;
        @(negedge clk_in);
        frame_in = 1'b0;
        checks++;
        if (frame_missed_out !== 1'b1) begin
            errors++;
            $display("FAIL frame_missed: missed=%b required 1", frame_missed_out);
        end
        commits = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (commit_out === 1'b1) commits++;
        end
        checks++;
        if (commits != 1) begin
            errors++;
            $display("FAIL commit_count: commits=%0d required 1", commits);
        end
    endtask

    task automatic test_start_abort();
        logic signed [13:0] ez;
        load_ramp();
        pulse_start();
        do_frame(0);
        do_frame(700);
        curr_time_in = 18'd800;
        frame_in = 1'b1;
        @(negedge clk_in);
        frame_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_before: busy=%b required 1", busy_out);
        end
        start_in = 1'b1;
        frame_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        frame_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0 || block_visible_out !== '0 || frame_missed_out !== 1'b0 || commit_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: busy=%b visible=%h missed=%b commit=%b required all 0",
                     busy_out, block_visible_out, frame_missed_out, commit_out);
        end
        do_frame(0);
        ez = 14'sd100;
        checks++;
        if (block_visible_out[0] !== 1'b1 || block_ID_out[0] !== 8'd0 || block_z_out[0] !== ez) begin
            errors++;
            $display("FAIL abort_refetch: vis=%b id=%0d z=%0d required vis=1 id=0 z=%0d",
                     block_visible_out[0], block_ID_out[0], block_z_out[0], ez);
        end
    endtask

    task automatic test_random();
        int t, cur, z, id;
        logic [45:0] r;
        logic signed [13:0] ez;
        fill_sentinel();
        t = 0;
        for (int i = 0; i < 60; i++) begin
            t += $urandom_range(30, 700);
            if ($urandom_range(0, 9) == 0) t += 4500;
            if (t > 200000) break;
            rom_mem[i] = mk_rec(t, $urandom_range(0, 4095), $urandom_range(0, 4095),
                                $urandom_range(0, 1), $urandom_range(0, 7));
        end
        pulse_start();
        model_start();
        cur = 0;
        for (int f = 0; f < 30; f++) begin
            cur += $urandom_range(0, 1000);
            do_frame(cur);
            model_frame(cur);
            for (int s = 0; s < NS; s++) begin
                checks++;
                if (s < m_win.size()) begin
                    id = m_win[s];
                    r  = rom_mem[id];
                    z  = rec_time(id) - cur;
                    if (z > 8191) z = 8191;
                    if (z < -8192) z = -8192;
                    ez = 14'(z);
                    if (block_visible_out[s] !== 1'b1 || block_ID_out[s] !== 8'(id) || block_z_out[s] !== ez ||
                        block_x_out[s] !== r[27:16] || block_y_out[s] !== r[15:4] ||
                        block_color_out[s] !== r[3] || block_direction_out[s] !== r[2:0]) begin
                        errors++;
                        $display("FAIL rand f%0d slot%0d: vis=%b id=%0d z=%0d x=%0d y=%0d c=%b d=%0d required vis=1 id=%0d z=%0d x=%0d y=%0d c=%b d=%0d",
                                 f, s, block_visible_out[s], block_ID_out[s], block_z_out[s], block_x_out[s], block_y_out[s],
                                 block_color_out[s], block_direction_out[s], id, ez, r[27:16], r[15:4], r[3], r[2:0]);
                    end
                end else if (block_visible_out[s] !== 1'b0 || block_z_out[s] !== 14'sd0) begin
                    errors++;
                    $display("FAIL rand f%0d slot%0d: vis=%b z=%0d required vis=0 z=0", f, s, block_visible_out[s], block_z_out[s]);
                end
            end
            @(negedge clk_in);
        end
    endtask

    initial begin
        rst_in = 1'b1; start_in = 1'b0; frame_in = 1'b0; curr_time_in = '0;
        start_b = 1'b0; frame_b = 1'b0; time_b = '0;
        fill_sentinel();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        test_reset();
        test_fill_and_retire();
        test_end_of_map();
        test_lookahead();
        test_back_to_back();
        test_start_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
